// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and sizes for the SPI frame-buffer loader.
package matrix_pkg;

    localparam int ADR_W           = 10;
    localparam int RGB_W           = 3;
    localparam int FRAME_PIXELS    = 1024;
    localparam int BYTES_PER_FRAME = 512;

    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(FRAME_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WR_EVEN,
        WR_ODD,
        DONE
    } loader_state_t;

endpackage

// File: rtl/matrix_spi_loader_sync2.sv
// sync2: two-flop synchronizer with asynchronous active-high reset.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/matrix_spi_loader.sv
// matrix_spi_loader: receives SPI bytes carrying two 3-bit pixels each and
// writes them sequentially into a 32x32 frame buffer.
module matrix_spi_loader
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             sck,
    input  logic             sdi,
    input  logic             cs,
    output logic             we,
    output logic [ADR_W-1:0] adr_out,
    output logic [RGB_W-1:0] rgb_out,
    output logic             frame_done,
    output logic             overflow
);

    logic             w_sck;
    logic             w_sdi;
    logic             w_cs;
    logic             w_live;
    logic             w_sck_rise;
    logic             w_cs_rise;
    logic             w_cs_fall;
    logic             w_start;
    logic             r_sck_d;
    logic             r_cs_d;
    logic [1:0]       r_live;
    logic [7:0]       r_shift;
    logic [7:0]       r_byte;
    logic [2:0]       r_bitcnt;
    logic             r_byte_rdy;
    logic             r_full;
    logic             r_cs_pend;
    logic [ADR_W-1:0] r_pix;
    logic             r_we;
    logic [ADR_W-1:0] r_adr;
    logic [RGB_W-1:0] r_rgb;
    logic             r_done;
    logic             r_overflow;
    loader_state_t    r_state;

    sync2 u_sync_sck (.clk(clk), .reset(reset), .i_d(sck), .o_q(w_sck));
    sync2 u_sync_sdi (.clk(clk), .reset(reset), .i_d(sdi), .o_q(w_sdi));
    sync2 u_sync_cs  (.clk(clk), .reset(reset), .i_d(cs),  .o_q(w_cs));

    // Edges are masked until the synchronizers have refilled after reset, so a
    // line already high at release is not mistaken for a fresh rise.
    assign w_live     = &r_live;
    assign w_sck_rise = w_live & w_sck & ~r_sck_d;
    assign w_cs_rise  = w_live & w_cs & ~r_cs_d;
    assign w_cs_fall  = w_live & ~w_cs & r_cs_d;
    assign w_start    = (r_state == IDLE) & (w_cs_rise | r_cs_pend);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sck_d    <= 1'b0;
            r_cs_d     <= 1'b0;
            r_live     <= '0;
            r_shift    <= '0;
            r_byte     <= '0;
            r_bitcnt   <= '0;
            r_byte_rdy <= 1'b0;
        end else begin
            r_sck_d    <= w_sck;
            r_cs_d     <= w_cs;
            r_byte_rdy <= 1'b0;
            if (!w_live)
                r_live <= r_live + 2'd1;
            if (w_start || w_cs_fall)
                r_bitcnt <= '0;
            else if (w_sck_rise && w_cs) begin
                r_shift  <= {r_shift[6:0], w_sdi};
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                    r_byte     <= {r_shift[6:0], w_sdi};
                    r_byte_rdy <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pix      <= '0;
            r_full     <= 1'b0;
            r_cs_pend  <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= '0;
            r_rgb      <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // A rise seen outside IDLE is remembered until IDLE can act on it.
            r_cs_pend <= (r_state != IDLE) && !w_cs_fall && (r_cs_pend || w_cs_rise);
            if (r_byte_rdy && r_full)
                r_overflow <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state    <= RECV;
                        r_pix      <= '0;
                        r_full     <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                RECV: begin
                    if (!w_cs)
                        r_state <= IDLE;
                    else if (r_byte_rdy) begin
                        r_state <= WR_EVEN;
                        r_we    <= 1'b1;
                        r_adr   <= r_pix;
                        r_rgb   <= r_byte[6:4];
                        r_pix   <= r_pix + ADR_W'(1);
                    end
                end
                WR_EVEN: begin
                    r_state <= WR_ODD;
                    r_adr   <= r_pix;
                    r_rgb   <= r_byte[2:0];
                    r_pix   <= r_pix + ADR_W'(1);
                end
                WR_ODD: begin
                    r_we <= 1'b0;
                    if (r_adr == LAST_ADR) begin
                        r_state <= DONE;
                        r_full  <= 1'b1;
                        r_done  <= 1'b1;
                    end else
                        r_state <= (!w_cs || r_cs_pend) ? IDLE : RECV;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign we         = r_we;
    assign adr_out    = r_adr;
    assign rgb_out    = r_rgb;
    assign frame_done = r_done;
    assign overflow   = r_overflow;

endmodule
